// File: rtl/gen_interrupciones_pkg.sv
// Shared definitions for the interrupt generator: arbiter states,
// config byte field positions and default prescaler divides.
package gen_interrupciones_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned BASE_MSB = 7;
  localparam int unsigned BASE_LSB = 6;
  localparam int unsigned THR_MSB  = 5;
  localparam int unsigned THR_LSB  = 0;
  localparam int unsigned THR_W    = THR_MSB - THR_LSB + 1;

  localparam int unsigned DEF_DIV0 = 1;
  localparam int unsigned DEF_DIV1 = 16;
  localparam int unsigned DEF_DIV2 = 256;
  localparam int unsigned DEF_DIV3 = 4096;

endpackage

// File: rtl/gen_interrupciones_sync_flanco.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector; rise_o is high for one cycle per synchronized edge.
module sync_flanco (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/gen_interrupciones.sv
// Interrupt source block: programmable timer plus synchronized external
// line, arbitrated into single-cycle requests spaced at least MIN_GAP apart.
module gen_interrupciones
  import gen_interrupciones_pkg::*;
#(
  parameter int unsigned DIV0    = DEF_DIV0,
  parameter int unsigned DIV1    = DEF_DIV1,
  parameter int unsigned DIV2    = DEF_DIV2,
  parameter int unsigned DIV3    = DEF_DIV3,
  parameter int unsigned PW      = 12,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] conf_data,
  input  logic       ext_irq,
  output logic       interrupcion,
  output logic       clock_out,
  output logic [1:0] irq_pending
);

  localparam int unsigned HW = $clog2(MIN_GAP);

  logic [1:0]       base_q, base_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic [THR_W-1:0] tick_q, tick_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [PW-1:0]    div_m1;
  logic             tmr_evt;
  logic             ext_rise;
  logic             ext_pend_q, ext_pend_d;
  logic             tmr_pend_q, tmr_pend_d;
  logic             serve_ext, serve_tmr;
  state_e           state_q;
  logic [HW-1:0]    hold_q;
  logic             irq_q, clk_q;

  sync_flanco u_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .d_i    (ext_irq),
    .rise_o (ext_rise)
  );

  always_comb begin
    unique case (base_q)
      2'b00:   div_m1 = PW'(DIV0 - 1);
      2'b01:   div_m1 = PW'(DIV1 - 1);
      2'b10:   div_m1 = PW'(DIV2 - 1);
      default: div_m1 = PW'(DIV3 - 1);
    endcase
  end

  always_comb begin
    base_d  = base_q;
    thr_d   = thr_q;
    presc_d = presc_q;
    tick_d  = tick_q;
    tmr_evt = 1'b0;
    if (enable) begin
      base_d  = conf_data[BASE_MSB:BASE_LSB];
      thr_d   = conf_data[THR_MSB:THR_LSB];
      presc_d = '0;
      tick_d  = '0;
    end else if (thr_q != '0) begin
      if (presc_q == div_m1) begin
        presc_d = '0;
        if (tick_q == thr_q - THR_W'(1)) begin
          tick_d  = '0;
          tmr_evt = 1'b1;
        end else begin
          tick_d = tick_q + THR_W'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Sets are applied after the FIRE clear so a same-cycle event is retained.
  always_comb begin
    ext_pend_d = ext_pend_q;
    tmr_pend_d = tmr_pend_q;
    if (irq_q)    ext_pend_d = 1'b0;
    if (clk_q)    tmr_pend_d = 1'b0;
    if (ext_rise) ext_pend_d = 1'b1;
    if (tmr_evt)  tmr_pend_d = 1'b1;
    if (enable)   tmr_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      thr_q      <= '0;
      presc_q    <= '0;
      tick_q     <= '0;
      ext_pend_q <= 1'b0;
      tmr_pend_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      thr_q      <= thr_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      ext_pend_q <= ext_pend_d;
      tmr_pend_q <= tmr_pend_d;
    end
  end

  // A timer event being discarded by a config write must not launch a pulse.
  assign serve_ext = ext_pend_q;
  assign serve_tmr = tmr_pend_q & ~enable;

  // The last HOLD cycle also acts as IDLE so back-to-back requests land
  // exactly MIN_GAP cycles apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      irq_q   <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      clk_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (serve_ext || serve_tmr) begin
            state_q <= FIRE;
            irq_q   <= serve_ext;
            clk_q   <= !serve_ext;
          end
        end
        FIRE: begin
          state_q <= HOLD;
          hold_q  <= HW'(MIN_GAP - 2);
        end
        HOLD: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else if (serve_ext || serve_tmr) begin
            state_q <= FIRE;
            irq_q   <= serve_ext;
            clk_q   <= !serve_ext;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign interrupcion = irq_q;
  assign clock_out    = clk_q;
  assign irq_pending  = {tmr_pend_q, ext_pend_q};

endmodule
